io_responder: RTL and testbench

IO_RESPONDER -- requirements
Module: io_responder

---
 rtl/io_pkg.sv | 18 +
 rtl/io_fifo.sv | 58 +++++
 rtl/io_responder.sv | 124 ++++++++++++
 tb/tb_io_responder.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// rtl/io_pkg.sv - shared constants for the memory-mapped IO responder
package io_pkg;
   localparam logic [7:0] IO_PAGE      = 8'hFF;

   localparam logic [7:0] OFF_LED      = 8'h00;
   localparam logic [7:0] OFF_SW       = 8'h04;
   localparam logic [7:0] OFF_OUT_STAT = 8'h08;
   localparam logic [7:0] OFF_OUT_DATA = 8'h0C;
   localparam logic [7:0] OFF_IN_STAT  = 8'h10;
   localparam logic [7:0] OFF_IN_DATA  = 8'h14;
   localparam logic [7:0] OFF_TIMER    = 8'h18;

   localparam int STAT_FULL    = 0;
   localparam int STAT_EMPTY   = 1;
   localparam int STAT_OVF     = 2;
   localparam int STAT_CNT_LSB = 4;
   localparam int STAT_PRESENT = 0;
endpackage

// File: rtl/io_fifo.sv
// rtl/io_fifo.sv - synchronous FIFO with occupancy count; push while full is dropped unless popped
module io_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           din,
   output logic [WIDTH-1:0]           dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   always_comb begin
      do_pop   = pop && (count_q != '0);
      // A full FIFO can still accept a word when the head leaves in the same cycle
      do_push  = push && ((count_q != CW'(DEPTH)) || do_pop);
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_push && !do_pop)      count_d = count_q + CW'(1);
      else if (do_pop && !do_push) count_d = count_q - CW'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && do_push) mem_q[wr_ptr_q] <= din;
   end

   assign dout  = mem_q[rd_ptr_q];
   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;
endmodule

// File: rtl/io_responder.sv
// rtl/io_responder.sv - IO page decode, LED/switch/timer registers, output FIFO and input holding
module io_responder #(
   parameter int         FIFO_DEPTH = 4,
   parameter logic [7:0] IO_PAGE    = io_pkg::IO_PAGE
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] io_addr,
   input  logic [31:0] io_din,
   input  logic        io_we,
   input  logic        io_rd,
   output logic [31:0] io_dout,
   output logic [15:0] led,
   input  logic [15:0] sw,
   output logic [31:0] out_data,
   output logic        out_valid,
   input  logic        out_ready,
   input  logic [31:0] in_data,
   input  logic        in_valid,
   output logic        in_ready
);
   import io_pkg::*;

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic [15:0] led_q, led_d;
   logic [15:0] sw_meta_q, sw_sync_q;
   logic [31:0] timer_q, timer_d;
   logic        ovf_q, ovf_d;
   logic        present_q, present_d;
   logic [31:0] held_q, held_d;

   logic        sel, wr, rd;
   logic [7:0]  off;
   logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [CW-1:0] fifo_count;
   logic [31:0] stat_word;

   assign sel = (io_addr[15:8] == IO_PAGE);
   assign off = io_addr[7:0];
   assign wr  = sel && io_we;
   assign rd  = sel && io_rd;

   assign fifo_pop  = out_ready && !fifo_empty;
   assign fifo_push = wr && (off == OFF_OUT_DATA);

   always_comb begin
      led_d     = led_q;
      ovf_d     = ovf_q;
      present_d = present_q;
      held_d    = held_q;
      timer_d   = timer_q + 32'd1;
      if (wr && off == OFF_LED) led_d = io_din[15:0];
      if (wr && off == OFF_TIMER) timer_d = io_din;
      if (fifo_push && fifo_full && !fifo_pop) ovf_d = 1'b1;
      else if (wr && off == OFF_OUT_STAT && io_din[STAT_OVF]) ovf_d = 1'b0;
      // Capture and read-to-clear are exclusive: capture needs present low, clear needs it high
      if (in_valid && !present_q) begin
         present_d = 1'b1;
         held_d    = in_data;
      end else if (rd && off == OFF_IN_DATA && present_q) begin
         present_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         led_q     <= '0;
         sw_meta_q <= '0;
         sw_sync_q <= '0;
         timer_q   <= '0;
         ovf_q     <= 1'b0;
         present_q <= 1'b0;
         held_q    <= '0;
      end else begin
         led_q     <= led_d;
         sw_meta_q <= sw;
         sw_sync_q <= sw_meta_q;
         timer_q   <= timer_d;
         ovf_q     <= ovf_d;
         present_q <= present_d;
         held_q    <= held_d;
      end
   end

   io_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   (io_din),
      .dout  (out_data),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_comb begin
      stat_word = '0;
      stat_word[STAT_FULL]  = fifo_full;
      stat_word[STAT_EMPTY] = fifo_empty;
      stat_word[STAT_OVF]   = ovf_q;
      stat_word[STAT_CNT_LSB +: 4] = 4'(fifo_count);
   end

   always_comb begin
      io_dout = '0;
      if (sel) begin
         case (off)
            OFF_LED:      io_dout = {16'b0, led_q};
            OFF_SW:       io_dout = {16'b0, sw_sync_q};
            OFF_OUT_STAT: io_dout = stat_word;
            OFF_IN_STAT:  io_dout = {31'b0, present_q};
            OFF_IN_DATA:  io_dout = held_q;
            OFF_TIMER:    io_dout = timer_q;
            default:      io_dout = '0;
         endcase
      end
   end

   assign led       = led_q;
   assign out_valid = !fifo_empty;
   assign in_ready  = !present_q;
endmodule

// File: tb/tb_io_responder.sv
// tb/tb_io_responder.sv - directed vector table plus randomized run against a queue-based model
module tb_io_responder;
   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] io_addr;
   logic [31:0] io_din;
   logic        io_we, io_rd;
   logic [31:0] io_dout;
   logic [15:0] led;
   logic [15:0] sw;
   logic [31:0] out_data;
   logic        out_valid, out_ready;
   logic [31:0] in_data;
   logic        in_valid, in_ready;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   io_responder #(.FIFO_DEPTH(4), .IO_PAGE(8'hFF)) dut (
      .clk(clk), .rst(rst), .io_addr(io_addr), .io_din(io_din), .io_we(io_we),
      .io_rd(io_rd), .io_dout(io_dout), .led(led), .sw(sw), .out_data(out_data),
      .out_valid(out_valid), .out_ready(out_ready), .in_data(in_data),
      .in_valid(in_valid), .in_ready(in_ready)
   );

   typedef struct {
      logic        rst;
      logic [15:0] addr;
      logic [31:0] din;
      logic        we, rd, ordy, ival;
      logic [31:0] idata;
      logic [15:0] sw;
      logic        cd;
      logic [31:0] dout;
      logic        ov;
      logic [31:0] od;
      logic        ir;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(logic r, logic [15:0] a, logic [31:0] d, logic w, logic rdv,
                               logic ordy, logic iv, logic [31:0] idat, logic [15:0] s,
                               logic cd, logic [31:0] edout, logic eov, logic [31:0] eod,
                               logic eir);
      vec_t v;
      v.rst = r; v.addr = a; v.din = d; v.we = w; v.rd = rdv; v.ordy = ordy;
      v.ival = iv; v.idata = idat; v.sw = s; v.cd = cd; v.dout = edout;
      v.ov = eov; v.od = eod; v.ir = eir;
      return v;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, act, exp);
      end
   endtask

   // Reference model: registers as plain variables, the FIFO as a queue
   logic [15:0]  m_led, m_sw1, m_sw2;
   logic [31:0]  m_timer, m_held;
   bit           m_ovf, m_pres;
   logic [31:0]  m_q[$];
   localparam int M_DEPTH = 4;

   function automatic logic [31:0] m_dout();
      logic [3:0] cnt;
      if (io_addr[15:8] != 8'hFF) return 32'h0;
      cnt = 4'(m_q.size());
      case (io_addr[7:0])
         8'h00: return {16'h0, m_led};
         8'h04: return {16'h0, m_sw2};
         8'h08: return {24'h0, cnt, 1'b0, m_ovf, (m_q.size() == 0), (m_q.size() == M_DEPTH)};
         8'h10: return {31'h0, m_pres};
         8'h14: return m_held;
         8'h18: return m_timer;
         default: return 32'h0;
      endcase
   endfunction

   task automatic m_step();
      bit sel, pop, push;
      if (rst) begin
         m_led = 0; m_sw1 = 0; m_sw2 = 0; m_timer = 0; m_held = 0;
         m_ovf = 0; m_pres = 0; m_q.delete();
         return;
      end
      sel  = (io_addr[15:8] == 8'hFF);
      pop  = out_ready && (m_q.size() > 0);
      push = sel && io_we && io_addr[7:0] == 8'h0C;
      m_sw2 = m_sw1;
      m_sw1 = sw;
      if (sel && io_we && io_addr[7:0] == 8'h00) m_led = io_din[15:0];
      if (sel && io_we && io_addr[7:0] == 8'h08 && io_din[2]) m_ovf = 0;
      if (push && m_q.size() == M_DEPTH && !pop) m_ovf = 1;
      if (pop) void'(m_q.pop_front());
      if (push && m_q.size() < M_DEPTH) m_q.push_back(io_din);
      if (sel && io_we && io_addr[7:0] == 8'h18) m_timer = io_din;
      else m_timer = m_timer + 1;
      if (in_valid && !m_pres) begin
         m_pres = 1; m_held = in_data;
      end else if (sel && io_rd && io_addr[7:0] == 8'h14 && m_pres) begin
         m_pres = 0;
      end
   endtask

   task automatic apply(vec_t v);
      rst = v.rst; io_addr = v.addr; io_din = v.din; io_we = v.we; io_rd = v.rd;
      out_ready = v.ordy; in_valid = v.ival; in_data = v.idata; sw = v.sw;
   endtask

   task automatic finish_cycle();
      m_step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1; io_addr = 0; io_din = 0; io_we = 0; io_rd = 0; sw = 0;
      out_ready = 0; in_data = 0; in_valid = 0;
      repeat (2) begin @(negedge clk); finish_cycle(); end

      //       rst addr      din           we rd or iv idata         sw       cd dout          ov od     ir
      tbl.push_back(mk(1, 16'hFF00, 32'h0,        0, 1, 0, 0, 32'h0,        16'h0,   1, 32'h0,        0, 0,     1));
      tbl.push_back(mk(0, 16'hFF00, 32'h1234ABCD, 1, 1, 0, 0, 32'h0,        16'h0,   1, 32'h0,        0, 0,     1));
      tbl.push_back(mk(0, 16'hFF00, 32'h0,        0, 1, 0, 0, 32'h0,        16'h0,   1, 32'h0000ABCD, 0, 0,     1));
      tbl.push_back(mk(0, 16'h0000, 32'h0,        0, 1, 0, 0, 32'h0,        16'h0,   1, 32'h0,        0, 0,     1));
      tbl.push_back(mk(0, 16'hFF0C, 32'h11,       1, 0, 0, 0, 32'h0,        16'h0,   1, 32'h0,        0, 0,     1));
      tbl.push_back(mk(0, 16'hFF0C, 32'h22,       1, 0, 0, 0, 32'h0,        16'h0,   1, 32'h0,        1, 32'h11, 1));
      tbl.push_back(mk(0, 16'hFF0C, 32'h33,       1, 0, 0, 0, 32'h0,        16'h0,   1, 32'h0,        1, 32'h11, 1));
      tbl.push_back(mk(0, 16'hFF0C, 32'h44,       1, 0, 0, 0, 32'h0,        16'h0,   1, 32'h0,        1, 32'h11, 1));
      tbl.push_back(mk(0, 16'hFF0C, 32'h55,       1, 0, 0, 0, 32'h0,        16'h0,   1, 32'h0,        1, 32'h11, 1));
      tbl.push_back(mk(0, 16'hFF08, 32'h0,        0, 1, 0, 0, 32'h0,        16'h0,   1, 32'h45,       1, 32'h11, 1));
      tbl.push_back(mk(0, 16'hFF08, 32'h0,        0, 1, 1, 0, 32'h0,        16'h0,   1, 32'h45,       1, 32'h11, 1));
      tbl.push_back(mk(0, 16'hFF08, 32'h0,        0, 1, 1, 0, 32'h0,        16'h0,   1, 32'h34,       1, 32'h22, 1));
      tbl.push_back(mk(0, 16'hFF08, 32'h0,        0, 1, 1, 0, 32'h0,        16'h0,   1, 32'h24,       1, 32'h33, 1));
      tbl.push_back(mk(0, 16'hFF08, 32'h0,        0, 1, 1, 0, 32'h0,        16'h0,   1, 32'h14,       1, 32'h44, 1));
      tbl.push_back(mk(0, 16'hFF08, 32'h0,        0, 1, 0, 0, 32'h0,        16'h0,   1, 32'h06,       0, 0,     1));
      tbl.push_back(mk(0, 16'hFF08, 32'h4,        1, 1, 0, 0, 32'h0,        16'h0,   1, 32'h06,       0, 0,     1));
      tbl.push_back(mk(0, 16'hFF08, 32'h0,        0, 1, 0, 0, 32'h0,        16'h0,   1, 32'h02,       0, 0,     1));
      tbl.push_back(mk(0, 16'hFF0C, 32'hA1,       1, 0, 0, 0, 32'h0,        16'h0,   1, 32'h0,        0, 0,     1));
      tbl.push_back(mk(0, 16'hFF0C, 32'hA2,       1, 0, 0, 0, 32'h0,        16'h0,   1, 32'h0,        1, 32'hA1, 1));
      tbl.push_back(mk(0, 16'hFF0C, 32'hA3,       1, 0, 0, 0, 32'h0,        16'h0,   1, 32'h0,        1, 32'hA1, 1));
      tbl.push_back(mk(0, 16'hFF0C, 32'hA4,       1, 0, 0, 0, 32'h0,        16'h0,   1, 32'h0,        1, 32'hA1, 1));
      tbl.push_back(mk(0, 16'hFF0C, 32'hA5,       1, 0, 1, 0, 32'h0,        16'h0,   1, 32'h0,        1, 32'hA1, 1));
      tbl.push_back(mk(0, 16'hFF08, 32'h0,        0, 1, 0, 0, 32'h0,        16'h0,   1, 32'h41,       1, 32'hA2, 1));
      tbl.push_back(mk(0, 16'hFF08, 32'h0,        0, 0, 1, 0, 32'h0,        16'h0,   1, 32'h41,       1, 32'hA2, 1));
      tbl.push_back(mk(0, 16'hFF08, 32'h0,        0, 0, 1, 0, 32'h0,        16'h0,   1, 32'h30,       1, 32'hA3, 1));
      tbl.push_back(mk(0, 16'hFF08, 32'h0,        0, 0, 1, 0, 32'h0,        16'h0,   1, 32'h20,       1, 32'hA4, 1));
      tbl.push_back(mk(0, 16'hFF08, 32'h0,        0, 0, 1, 0, 32'h0,        16'h0,   1, 32'h10,       1, 32'hA5, 1));
      tbl.push_back(mk(0, 16'hFF08, 32'h0,        0, 1, 0, 0, 32'h0,        16'h0,   1, 32'h02,       0, 0,     1));
      tbl.push_back(mk(0, 16'hFF10, 32'h0,        0, 1, 0, 1, 32'hCAFE0001, 16'h0,   1, 32'h0,        0, 0,     1));
      tbl.push_back(mk(0, 16'hFF10, 32'h0,        0, 1, 0, 1, 32'hDEADBEEF, 16'h0,   1, 32'h1,        0, 0,     0));
      tbl.push_back(mk(0, 16'hFF14, 32'h0,        0, 1, 0, 0, 32'h0,        16'h0,   1, 32'hCAFE0001, 0, 0,     0));
      tbl.push_back(mk(0, 16'hFF10, 32'h0,        0, 1, 0, 0, 32'h0,        16'h0,   1, 32'h0,        0, 0,     1));
      tbl.push_back(mk(0, 16'hFF14, 32'h0,        0, 1, 0, 0, 32'h0,        16'h0,   1, 32'hCAFE0001, 0, 0,     1));
      tbl.push_back(mk(0, 16'hFF10, 32'h0,        0, 1, 0, 0, 32'h0,        16'h0,   1, 32'h0,        0, 0,     1));
      tbl.push_back(mk(0, 16'hFF18, 32'hFFFFFFFE, 1, 0, 0, 0, 32'h0,        16'h0,   0, 32'h0,        0, 0,     1));
      tbl.push_back(mk(0, 16'hFF18, 32'h0,        0, 1, 0, 0, 32'h0,        16'h0,   1, 32'hFFFFFFFE, 0, 0,     1));
      tbl.push_back(mk(0, 16'hFF18, 32'h0,        0, 1, 0, 0, 32'h0,        16'h0,   1, 32'hFFFFFFFF, 0, 0,     1));
      tbl.push_back(mk(0, 16'hFF18, 32'h0,        0, 1, 0, 0, 32'h0,        16'h0,   1, 32'h00000000, 0, 0,     1));
      tbl.push_back(mk(0, 16'hFF04, 32'h0,        0, 1, 0, 0, 32'h0,        16'h00F0, 1, 32'h0,       0, 0,     1));
      tbl.push_back(mk(0, 16'hFF04, 32'h0,        0, 1, 0, 0, 32'h0,        16'h00F0, 1, 32'h0,       0, 0,     1));
      tbl.push_back(mk(0, 16'hFF04, 32'h0,        0, 1, 0, 0, 32'h0,        16'h00F0, 1, 32'h00F0,    0, 0,     1));
      tbl.push_back(mk(0, 16'hFF0C, 32'hB1,       1, 0, 0, 0, 32'h0,        16'h00F0, 1, 32'h0,       0, 0,     1));
      tbl.push_back(mk(0, 16'hFF0C, 32'hB2,       1, 0, 0, 0, 32'h0,        16'h00F0, 1, 32'h0,       1, 32'hB1, 1));
      tbl.push_back(mk(1, 16'hFF0C, 32'hB3,       1, 0, 0, 1, 32'h77,       16'h00F0, 1, 32'h0,       1, 32'hB1, 1));
      tbl.push_back(mk(0, 16'hFF08, 32'h0,        0, 1, 0, 0, 32'h0,        16'h00F0, 1, 32'h02,      0, 0,     1));
      tbl.push_back(mk(0, 16'h0100, 32'h5555,     1, 1, 0, 0, 32'h0,        16'h00F0, 1, 32'h0,       0, 0,     1));
      tbl.push_back(mk(0, 16'hFF00, 32'h0,        0, 1, 0, 0, 32'h0,        16'h00F0, 1, 32'h0,       0, 0,     1));
      tbl.push_back(mk(0, 16'hFF20, 32'hFFFF,     1, 1, 0, 0, 32'h0,        16'h00F0, 1, 32'h0,       0, 0,     1));
      tbl.push_back(mk(0, 16'hFF10, 32'h0,        0, 1, 0, 0, 32'h0,        16'h00F0, 1, 32'h0,       0, 0,     1));

      foreach (tbl[i]) begin
         apply(tbl[i]);
         @(negedge clk);
         if (tbl[i].cd) chk($sformatf("dir%0d_dout", i), io_dout, tbl[i].dout);
         chk($sformatf("dir%0d_out_valid", i), {31'b0, out_valid}, {31'b0, tbl[i].ov});
         if (tbl[i].ov) chk($sformatf("dir%0d_out_data", i), out_data, tbl[i].od);
         chk($sformatf("dir%0d_in_ready", i), {31'b0, in_ready}, {31'b0, tbl[i].ir});
         finish_cycle();
      end

      for (int c = 0; c < 3000; c++) begin
         logic [7:0] offs [9];
         offs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C, 8'h00};
         offs[8] = 8'($urandom);
         rst       = ($urandom_range(0, 199) == 0);
         io_addr   = {(($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'hFF),
                      offs[$urandom_range(0, 8)]};
         io_din    = ($urandom_range(0, 3) == 0) ? 32'h4 : $urandom;
         io_we     = ($urandom_range(0, 9) < 4);
         io_rd     = ($urandom_range(0, 1) == 1);
         out_ready = ($urandom_range(0, 2) != 0);
         in_valid  = ($urandom_range(0, 2) == 0);
         in_data   = $urandom;
         if ($urandom_range(0, 15) == 0) sw = 16'($urandom);
         @(negedge clk);
         chk("rnd_dout", io_dout, m_dout());
         chk("rnd_out_valid", {31'b0, out_valid}, {31'b0, m_q.size() > 0});
         if (m_q.size() > 0) chk("rnd_out_data", out_data, m_q[0]);
         chk("rnd_in_ready", {31'b0, in_ready}, {31'b0, !m_pres});
         chk("rnd_led", {16'b0, led}, {16'b0, m_led});
         finish_cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
